// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq: multi-cycle ALU for the datapath execute stage.
//
// Single-cycle ADD/SUB/AND/OR, iterative shifts (1 bit per cycle) and an
// unsigned shift-add multiply. Holds an internal accumulator (ACC). Uses a
// valid/ready handshake on both sides, and registers its result flags.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  command handshake; in_ready only while idle
//   op              000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA, 111 MUL
//   a_sel           0: A = da, 1: A = ACC (value at accept)
//   acc_ctl         00 none, 01 ACC<=result, 10 clear, 11 complement
//   da, db, shamt   operands and shift count
//   out_valid/ready result handshake; dc and flags held while out_valid
//   dc              result
//   overflow        signed ADD/SUB overflow, MUL high half nonzero
//   carry           ADD carry-out / SUB no-borrow, 0 otherwise
//   zero, negative  derived from dc
//   busy            not idle
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter bit          MUL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic               a_sel,
    input  logic [1:0]         acc_ctl,
    input  logic [WIDTH-1:0]   da,
    input  logic [WIDTH-1:0]   db,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dc,
    output logic               overflow,
    output logic               carry,
    output logic               zero,
    output logic               negative,
    output logic               busy
);

    localparam int unsigned CNT_W = SHAMT_W + 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSll = 3'b100;
    localparam logic [2:0] OpSrl = 3'b101;
    localparam logic [2:0] OpSra = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dc_q, dc_d;
    logic             ovf_q, ovf_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       ctl_q, ctl_d;
    // Shift operand, or low product half / remaining multiplier bits for MUL.
    logic [WIDTH-1:0] work_q, work_d;
    // High product half for MUL.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Single-cycle arithmetic on the incoming command.
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    assign opa     = a_sel ? acc_q : da;
    assign opb     = (op == OpSub) ? ~db : db;
    assign sum     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, (op == OpSub)};
    assign add_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) & (sum[WIDTH-1] != opa[WIDTH-1]);

    // One iteration of the current multi-cycle operation.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_work, step_hi;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
        step_hi   = hi_q;
        step_work = work_q;
        unique case (op_q)
            OpSll:   step_work = {work_q[WIDTH-2:0], 1'b0};
            OpSrl:   step_work = {1'b0, work_q[WIDTH-1:1]};
            OpSra:   step_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OpMul: begin
                // Shift {carry, hi + mcand?, work} right by one.
                step_hi   = mul_sum[WIDTH:1];
                step_work = {mul_sum[0], work_q[WIDTH-1:1]};
            end
            default: step_work = work_q;
        endcase
    end

    logic             fin;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic             res_carry;
    logic [1:0]       fin_ctl;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        dc_d      = dc_q;
        ovf_d     = ovf_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        op_d      = op_q;
        ctl_d     = ctl_q;
        work_d    = work_q;
        hi_d      = hi_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        fin       = 1'b0;
        res       = '0;
        res_ovf   = 1'b0;
        res_carry = 1'b0;
        fin_ctl   = ctl_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = op;
                    ctl_d   = acc_ctl;
                    fin_ctl = acc_ctl;
                    if (acc_ctl[1]) begin
                        // Clear / complement ignore op entirely.
                        fin = 1'b1;
                        res = acc_ctl[0] ? ~acc_q : '0;
                    end else begin
                        unique case (op)
                            OpAdd, OpSub: begin
                                fin       = 1'b1;
                                res       = sum[WIDTH-1:0];
                                res_carry = sum[WIDTH];
                                res_ovf   = add_ovf;
                            end
                            OpAnd: begin
                                fin = 1'b1;
                                res = opa & db;
                            end
                            OpOr: begin
                                fin = 1'b1;
                                res = opa | db;
                            end
                            OpSll, OpSrl, OpSra: begin
                                if (shamt == '0) begin
                                    fin = 1'b1;
                                    res = opa;
                                end else begin
                                    state_d = StExec;
                                    work_d  = opa;
                                    cnt_d   = {1'b0, shamt};
                                end
                            end
                            OpMul: begin
                                if (MUL_EN) begin
                                    state_d = StExec;
                                    work_d  = db;
                                    hi_d    = '0;
                                    mcand_d = opa;
                                    cnt_d   = CNT_W'(WIDTH);
                                end else begin
                                    fin     = 1'b1;
                                    res     = '0;
                                    res_ovf = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StExec: begin
                work_d = step_work;
                hi_d   = step_hi;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fin     = 1'b1;
                    res     = step_work;
                    res_ovf = (op_q == OpMul) ? (|step_hi) : 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Result, flags and ACC all update on entry to DONE.
        if (fin) begin
            state_d = StDone;
            dc_d    = res;
            ovf_d   = res_ovf;
            carry_d = res_carry;
            zero_d  = (res == '0);
            neg_d   = res[WIDTH-1];
            unique case (fin_ctl)
                2'b01:   acc_d = res;
                2'b10:   acc_d = '0;
                2'b11:   acc_d = ~acc_q;
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            dc_q    <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            ctl_q   <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dc_q    <= dc_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            ctl_q   <= ctl_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign dc        = dc_q;
    assign overflow  = ovf_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq: directed vector table, hand-written handshake/reset sequences and
// randomized commands checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        a_sel;
    logic [1:0]  acc_ctl;
    logic [15:0] da;
    logic [15:0] db;
    logic [3:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dc;
    logic        overflow;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        busy;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH  (16),
        .SHAMT_W(4),
        .MUL_EN (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a_sel    (a_sel),
        .acc_ctl  (acc_ctl),
        .da       (da),
        .db       (db),
        .shamt    (shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dc       (dc),
        .overflow (overflow),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: ACC mirror plus plain arithmetic on the command.
    logic [15:0] acc_m;

    task automatic model(input logic [2:0] m_op, input logic m_sel, input logic [1:0] m_ctl,
                         input logic [15:0] m_da, input logic [15:0] m_db,
                         input logic [3:0] m_sh, output logic [15:0] m_dc,
                         output logic [3:0] m_fl, output int m_lat);
        logic [15:0]        a;
        logic signed [15:0] sa16;
        logic [16:0]        s17;
        logic [31:0]        prod;
        int                 sr;
        logic               ovf, cy;
        a    = m_sel ? acc_m : m_da;
        ovf  = 1'b0;
        cy   = 1'b0;
        m_lat = 1;
        if (m_ctl == 2'b10) begin
            m_dc  = 16'h0000;
            acc_m = 16'h0000;
        end else if (m_ctl == 2'b11) begin
            m_dc  = ~acc_m;
            acc_m = ~acc_m;
        end else begin
            case (m_op)
                3'b000: begin
                    s17  = {1'b0, a} + {1'b0, m_db};
                    m_dc = s17[15:0];
                    cy   = s17[16];
                    sr   = int'($signed(a)) + int'($signed(m_db));
                    ovf  = (sr > 32767) || (sr < -32768);
                end
                3'b001: begin
                    s17  = {1'b0, a} + {1'b0, ~m_db} + 17'd1;
                    m_dc = s17[15:0];
                    cy   = s17[16];
                    sr   = int'($signed(a)) - int'($signed(m_db));
                    ovf  = (sr > 32767) || (sr < -32768);
                end
                3'b010: m_dc = a & m_db;
                3'b011: m_dc = a | m_db;
                3'b100: begin m_dc = a << m_sh; m_lat = 1 + int'(m_sh); end
                3'b101: begin m_dc = a >> m_sh; m_lat = 1 + int'(m_sh); end
                3'b110: begin
                    sa16  = a;
                    m_dc  = sa16 >>> m_sh;
                    m_lat = 1 + int'(m_sh);
                end
                default: begin
                    prod  = 32'(a) * 32'(m_db);
                    m_dc  = prod[15:0];
                    ovf   = (prod[31:16] != 16'h0000);
                    m_lat = 17;
                end
            endcase
            if (m_ctl == 2'b01) acc_m = m_dc;
        end
        m_fl = {ovf, cy, (m_dc == 16'h0000), m_dc[15]};
    endtask

    // Issue one command with out_ready high; returns result, flags {ovf,carry,zero,neg}
    // and cycles from accept edge to out_valid. Returns at the negedge with out_valid seen.
    task automatic run_cmd(input logic [2:0] c_op, input logic c_sel, input logic [1:0] c_ctl,
                           input logic [15:0] c_da, input logic [15:0] c_db,
                           input logic [3:0] c_sh, output logic [15:0] r_dc,
                           output logic [3:0] r_fl, output int r_lat);
        int n;
        @(negedge clk);
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready before command: got 0 expected 1");
        end
        in_valid  = 1'b1;
        op        = c_op;
        a_sel     = c_sel;
        acc_ctl   = c_ctl;
        da        = c_da;
        db        = c_db;
        shamt     = c_sh;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            da       = 16'hDEAD;
            db       = 16'hBEEF;
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) begin
            errors++;
            $display("FAIL timeout waiting for out_valid: got 0 expected 1");
        end
        r_dc  = dc;
        r_fl  = {overflow, carry, zero, negative};
        r_lat = n;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        a_sel;
        logic [1:0]  ctl;
        logic [15:0] da;
        logic [15:0] db;
        logic [3:0]  shamt;
        logic [15:0] e_dc;
        logic [3:0]  e_fl;   // {overflow, carry, zero, negative}
        int          e_lat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    logic [15:0] g_dc, m_dc;
    logic [3:0]  g_fl, m_fl;
    int          g_lat, m_lat;
    logic [15:0] edges[4];

    initial begin
        vecs[0]  = '{3'b000, 1'b0, 2'b00, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b1001, 1};
        vecs[1]  = '{3'b001, 1'b0, 2'b00, 16'h0005, 16'h0007, 4'd0,  16'hFFFE, 4'b0001, 1};
        vecs[2]  = '{3'b001, 1'b0, 2'b00, 16'h0007, 16'h0005, 4'd0,  16'h0002, 4'b0100, 1};
        vecs[3]  = '{3'b010, 1'b0, 2'b00, 16'hF0F0, 16'h3C3C, 4'd0,  16'h3030, 4'b0000, 1};
        vecs[4]  = '{3'b011, 1'b0, 2'b00, 16'h0000, 16'h0000, 4'd0,  16'h0000, 4'b0010, 1};
        vecs[5]  = '{3'b110, 1'b0, 2'b00, 16'h8000, 16'h0000, 4'd4,  16'hF800, 4'b0001, 5};
        vecs[6]  = '{3'b101, 1'b0, 2'b00, 16'h8000, 16'h0000, 4'd4,  16'h0800, 4'b0000, 5};
        vecs[7]  = '{3'b100, 1'b0, 2'b00, 16'h0001, 16'h0000, 4'd15, 16'h8000, 4'b0001, 16};
        vecs[8]  = '{3'b100, 1'b0, 2'b00, 16'h1234, 16'h0000, 4'd0,  16'h1234, 4'b0000, 1};
        vecs[9]  = '{3'b111, 1'b0, 2'b00, 16'h0100, 16'h0100, 4'd0,  16'h0000, 4'b1010, 17};
        vecs[10] = '{3'b111, 1'b0, 2'b00, 16'h00FF, 16'h0003, 4'd0,  16'h02FD, 4'b0000, 17};
        vecs[11] = '{3'b011, 1'b0, 2'b10, 16'h1111, 16'h2222, 4'd0,  16'h0000, 4'b0010, 1};
        vecs[12] = '{3'b000, 1'b0, 2'b11, 16'h1111, 16'h2222, 4'd0,  16'hFFFF, 4'b0001, 1};
        vecs[13] = '{3'b000, 1'b1, 2'b01, 16'h5555, 16'h0001, 4'd0,  16'h0000, 4'b0110, 1};
        vecs[14] = '{3'b000, 1'b1, 2'b00, 16'h0005, 16'h0000, 4'd0,  16'h0000, 4'b0010, 1};
        vecs[15] = '{3'b000, 1'b0, 2'b01, 16'h1234, 16'h0000, 4'd0,  16'h1234, 4'b0000, 1};
        vecs[16] = '{3'b001, 1'b1, 2'b00, 16'h0000, 16'h0234, 4'd0,  16'h1000, 4'b0100, 1};
        vecs[17] = '{3'b110, 1'b0, 2'b00, 16'h4000, 16'h0000, 4'd3,  16'h0800, 4'b0000, 4};
        vecs[18] = '{3'b000, 1'b0, 2'b00, 16'h8000, 16'h8000, 4'd0,  16'h0000, 4'b1110, 1};
        edges = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

        rst = 1'b1; in_valid = 1'b0; op = '0; a_sel = 1'b0; acc_ctl = '0;
        da = '0; db = '0; shamt = '0; out_ready = 1'b0;
        acc_m = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dc", 32'(dc), 32'd0);
        check("reset flags", 32'({overflow, carry, zero, negative}), 32'd0);

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            model(vecs[i].op, vecs[i].a_sel, vecs[i].ctl, vecs[i].da, vecs[i].db,
                  vecs[i].shamt, m_dc, m_fl, m_lat);
            run_cmd(vecs[i].op, vecs[i].a_sel, vecs[i].ctl, vecs[i].da, vecs[i].db,
                    vecs[i].shamt, g_dc, g_fl, g_lat);
            check($sformatf("vec%0d dc", i), 32'(g_dc), 32'(vecs[i].e_dc));
            check($sformatf("vec%0d flags", i), 32'(g_fl), 32'(vecs[i].e_fl));
            check($sformatf("vec%0d latency", i), 32'(g_lat), 32'(vecs[i].e_lat));
        end

        // Back-pressure: result held for 3 cycles, second command waits for handshake.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; a_sel = 1'b0; acc_ctl = 2'b00;
        da = 16'h0001; db = 16'h0002; shamt = 4'd0; out_ready = 1'b0;
        @(negedge clk);
        da = 16'h000A; db = 16'h000A;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d dc", i), 32'(dc), 32'h0003);
            check($sformatf("hold%0d flags", i), 32'({overflow, carry, zero, negative}), 32'd0);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("after handshake out_valid", 32'(out_valid), 32'd0);
        check("after handshake in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("second cmd out_valid", 32'(out_valid), 32'd1);
        check("second cmd dc", 32'(dc), 32'h0014);

        // Reset in the middle of a MUL, with a nonzero ACC beforehand.
        model(3'b000, 1'b0, 2'b01, 16'h0055, 16'h0000, 4'd0, m_dc, m_fl, m_lat);
        run_cmd(3'b000, 1'b0, 2'b01, 16'h0055, 16'h0000, 4'd0, g_dc, g_fl, g_lat);
        check("acc preload dc", 32'(g_dc), 32'h0055);
        @(negedge clk);
        in_valid = 1'b1; op = 3'b111; a_sel = 1'b1; acc_ctl = 2'b01;
        da = 16'h0003; db = 16'h0003;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("mul busy before reset", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_m = 16'h0000;
        check("post-reset out_valid", 32'(out_valid), 32'd0);
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        check("post-reset dc", 32'(dc), 32'd0);
        check("post-reset busy", 32'(busy), 32'd0);
        run_cmd(3'b000, 1'b1, 2'b00, 16'h7777, 16'h0000, 4'd0, g_dc, g_fl, g_lat);
        check("post-reset ACC", 32'(g_dc), 32'd0);

        // Randomized commands against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  r_op;
            logic        r_sel;
            logic [1:0]  r_ctl;
            logic [15:0] r_da, r_db;
            logic [3:0]  r_sh;
            int          k;
            r_op  = 3'($urandom_range(0, 7));
            r_sel = 1'($urandom_range(0, 1));
            k     = int'($urandom_range(0, 7));
            r_ctl = (k < 4) ? 2'b00 : (k < 6) ? 2'b01 : (k == 6) ? 2'b10 : 2'b11;
            r_da  = 16'($urandom);
            r_db  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_da = edges[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) r_db = edges[$urandom_range(0, 3)];
            r_sh  = 4'($urandom_range(0, 15));
            model(r_op, r_sel, r_ctl, r_da, r_db, r_sh, m_dc, m_fl, m_lat);
            run_cmd(r_op, r_sel, r_ctl, r_da, r_db, r_sh, g_dc, g_fl, g_lat);
            check($sformatf("rand%0d op%0d dc", i, r_op), 32'(g_dc), 32'(m_dc));
            check($sformatf("rand%0d op%0d flags", i, r_op), 32'(g_fl), 32'(m_fl));
            check($sformatf("rand%0d op%0d latency", i, r_op), 32'(g_lat), 32'(m_lat));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
